cnn_seq_controller: RTL and testbench

- Top-level sequencer for the two-layer convolution datapath.
- Drives every datapath control strobe (L1 buffer load, L1 PE start, L2 picture write, L2 buffer load, L2 PE start, L3 result write) and consumes the datapath status flags.
- Runs the full L1 pass, then the full L2 pass, then reports done.
- Adds window counters and a stall watchdog for debug and bench visibility.

---
 rtl/cnn_ctrl_pkg.sv | 24 ++
 rtl/stall_watchdog.sv | 30 +++
 rtl/cnn_seq_controller.sv | 114 +++++++++++
 tb/tb_cnn_seq_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the two-layer convolution sequencer.
package cnn_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        L1_INIT  = 4'd1,
        L1_LOAD  = 4'd2,
        L1_START = 4'd3,
        L1_WAIT  = 4'd4,
        L1_STORE = 4'd5,
        L2_INIT  = 4'd6,
        L2_LOAD  = 4'd7,
        L2_START = 4'd8,
        L2_WAIT  = 4'd9,
        L2_STORE = 4'd10,
        DONE     = 4'd11,
        ERR      = 4'd12
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_TO_W    = 16;

endpackage

// File: rtl/stall_watchdog.sv
// Counts cycles spent in a stall-prone state; flags expiry on the cycle that
// would complete TIMEOUT cycles of residence. TIMEOUT = 0 disables it.
module stall_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != '1)
            cnt <= cnt + TO_W'(1);
    end

    // cnt holds completed cycles, so cnt == TIMEOUT-1 means this is the last one
    assign expired = (TIMEOUT != 0) && enable && (cnt >= LIMIT);

endmodule

// File: rtl/cnn_seq_controller.sv
// Moore sequencer for the L1 then L2 convolution passes, with window counters
// and a stall watchdog on the LOAD/WAIT states.
module cnn_seq_controller
    import cnn_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ldBufDoneL1,
    input  logic             ctrlDoneL1,
    input  logic             peDoneL1,
    input  logic             ldBufDoneL2,
    input  logic             ctrlDoneL2,
    input  logic             peDoneL2,
    output logic             initLdL1,
    output logic             startLdPicL2,
    output logic             ldBufL1,
    output logic             peStartL1,
    output logic             memWrEnL2,
    output logic             initLdL2,
    output logic             ldBufL2,
    output logic             peStartL2,
    output logic             memWrEnL3,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] l1_cnt,
    output logic [CNT_W-1:0] l2_cnt
);

    state_t state, state_nxt;
    logic   wait_armed;
    logic   in_stall;
    logic   wd_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign in_stall = (state == L1_LOAD) || (state == L1_WAIT) ||
                      (state == L2_LOAD) || (state == L2_WAIT);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = L1_INIT;
            L1_INIT:  state_nxt = L1_LOAD;
            L1_LOAD:  if (ldBufDoneL1) state_nxt = L1_START;
            L1_START: state_nxt = L1_WAIT;
            L1_WAIT:  if (wait_armed && peDoneL1) state_nxt = L1_STORE;
            L1_STORE: state_nxt = ctrlDoneL1 ? L2_INIT : L1_LOAD;
            L2_INIT:  state_nxt = L2_LOAD;
            L2_LOAD:  if (ldBufDoneL2) state_nxt = L2_START;
            L2_START: state_nxt = L2_WAIT;
            L2_WAIT:  if (wait_armed && peDoneL2) state_nxt = L2_STORE;
            L2_STORE: state_nxt = ctrlDoneL2 ? DONE : L2_LOAD;
            DONE:     state_nxt = start ? L1_INIT : IDLE;
            ERR:      if (start) state_nxt = L1_INIT;
            default:  state_nxt = IDLE;
        endcase
        if (wd_expired) state_nxt = ERR;
    end

    // A done flag still high from the previous window must not end this one
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_armed <= 1'b0;
        else
            wait_armed <= ((state == L1_WAIT) || (state == L2_WAIT)) && (state_nxt == state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_cnt <= '0;
            l2_cnt <= '0;
        end else if (state_nxt == L1_INIT) begin
            l1_cnt <= '0;
            l2_cnt <= '0;
        end else begin
            if (state == L1_STORE && l1_cnt != '1) l1_cnt <= l1_cnt + CNT_W'(1);
            if (state == L2_STORE && l2_cnt != '1) l2_cnt <= l2_cnt + CNT_W'(1);
        end
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nxt != state),
        .enable  (in_stall),
        .expired (wd_expired)
    );

    assign initLdL1     = (state == L1_INIT);
    assign startLdPicL2 = (state == L1_INIT);
    assign ldBufL1      = (state == L1_LOAD);
    assign peStartL1    = (state == L1_START);
    assign memWrEnL2    = (state == L1_STORE);
    assign initLdL2     = (state == L2_INIT);
    assign ldBufL2      = (state == L2_LOAD);
    assign peStartL2    = (state == L2_START);
    assign memWrEnL3    = (state == L2_STORE);
    assign busy         = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign done         = (state == DONE);
    assign error        = (state == ERR);

endmodule

// File: tb/tb_cnn_seq_controller.sv
// Directed bench for cnn_seq_controller: a per-cycle vector table plus scripted
// multi-window runs, watchdog, async reset and back-to-back sequences.
module tb_cnn_seq_controller;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic start, ldBufDoneL1, ctrlDoneL1, peDoneL1, ldBufDoneL2, ctrlDoneL2, peDoneL2;
    logic initLdL1, startLdPicL2, ldBufL1, peStartL1, memWrEnL2;
    logic initLdL2, ldBufL2, peStartL2, memWrEnL3, busy, done, error;
    logic [CNT_W-1:0] l1_cnt, l2_cnt;
    logic [11:0] outs;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cnn_seq_controller #(.CNT_W(CNT_W), .TIMEOUT(16), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ldBufDoneL1(ldBufDoneL1), .ctrlDoneL1(ctrlDoneL1), .peDoneL1(peDoneL1),
        .ldBufDoneL2(ldBufDoneL2), .ctrlDoneL2(ctrlDoneL2), .peDoneL2(peDoneL2),
        .initLdL1(initLdL1), .startLdPicL2(startLdPicL2), .ldBufL1(ldBufL1),
        .peStartL1(peStartL1), .memWrEnL2(memWrEnL2), .initLdL2(initLdL2),
        .ldBufL2(ldBufL2), .peStartL2(peStartL2), .memWrEnL3(memWrEnL3),
        .busy(busy), .done(done), .error(error), .l1_cnt(l1_cnt), .l2_cnt(l2_cnt)
    );

    assign outs = {initLdL1, startLdPicL2, ldBufL1, peStartL1, memWrEnL2, initLdL2,
                   ldBufL2, peStartL2, memWrEnL3, busy, done, error};

    // expected output word per state
    localparam logic [11:0] O_IDLE = 12'b0000_0000_0000;
    localparam logic [11:0] O_L1I  = 12'b1100_0000_0100;
    localparam logic [11:0] O_L1L  = 12'b0010_0000_0100;
    localparam logic [11:0] O_L1S  = 12'b0001_0000_0100;
    localparam logic [11:0] O_WAIT = 12'b0000_0000_0100;
    localparam logic [11:0] O_L1T  = 12'b0000_1000_0100;
    localparam logic [11:0] O_L2I  = 12'b0000_0100_0100;
    localparam logic [11:0] O_L2L  = 12'b0000_0010_0100;
    localparam logic [11:0] O_L2S  = 12'b0000_0001_0100;
    localparam logic [11:0] O_L2T  = 12'b0000_0000_1100;
    localparam logic [11:0] O_DONE = 12'b0000_0000_0010;
    localparam logic [11:0] O_ERR  = 12'b0000_0000_0001;

    // input word {start, ldL1, ctrlL1, peL1, ldL2, ctrlL2, peL2}
    localparam logic [6:0] I_NO  = 7'b0000000;
    localparam logic [6:0] I_ST  = 7'b1000000;
    localparam logic [6:0] I_LD1 = 7'b0100000;
    localparam logic [6:0] I_CT1 = 7'b0010000;
    localparam logic [6:0] I_PE1 = 7'b0001000;
    localparam logic [6:0] I_LD2 = 7'b0000100;
    localparam logic [6:0] I_CT2 = 7'b0000010;
    localparam logic [6:0] I_PE2 = 7'b0000001;

    typedef struct {
        logic [6:0]  in;
        logic [11:0] out;
        int          l1;
        int          l2;
    } vec_t;

    vec_t tbl[22];

    task automatic setv(input int i, input logic [6:0] in, input logic [11:0] o,
                        input int a, input int b);
        tbl[i].in  = in;
        tbl[i].out = o;
        tbl[i].l1  = a;
        tbl[i].l2  = b;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {start, ldBufDoneL1, ctrlDoneL1, peDoneL1, ldBufDoneL2, ctrlDoneL2, peDoneL2} = in;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(I_NO);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reactive stimulus: ldBufDone on the 3rd LOAD cycle, peDone on the 4th WAIT
    // cycle, ctrlDone on the n-th STORE of each layer.
    task automatic run(input int n1, input int n2, input bit pulse_st, input bit stale,
                       input bit hold_st, input bit stop_l2);
        int cyc = 0, lc = 0, wc = 0, layer = 0, s1 = 0, s2 = 0, il2 = 0, il2_at = -1, w1;
        bit fin = 1'b0;
        w1 = stale ? 7 : 9;
        start = 1'b1;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_st) start = 1'b0;
            {ldBufDoneL1, ctrlDoneL1, ldBufDoneL2, ctrlDoneL2, peDoneL2} = '0;
            peDoneL1 = stale;
            if (cyc == 1) chk("run_first_init", outs, O_L1I);
            if (ldBufL1 || ldBufL2) begin
                lc++;
                if (lc == 3) begin
                    if (ldBufL1) ldBufDoneL1 = 1'b1;
                    else         ldBufDoneL2 = 1'b1;
                end
            end else lc = 0;
            if (peStartL1) begin layer = 1; wc = 0; end
            if (peStartL2) begin layer = 2; wc = 0; end
            if (outs == O_WAIT) begin
                wc++;
                if (wc == 4) begin
                    if (layer == 1) peDoneL1 = 1'b1;
                    else            peDoneL2 = 1'b1;
                end
                if (pulse_st && layer == 1 && wc == 2) start = 1'b1;
            end
            if (memWrEnL2) begin
                s1++;
                ctrlDoneL1 = (s1 == n1);
                if (stale) chk("stale_wait_len", wc, 2);
            end
            if (memWrEnL3) begin
                s2++;
                ctrlDoneL2 = (s2 == n2);
            end
            if (initLdL2) begin
                il2++;
                il2_at = s1;
            end
            if (stop_l2 && ldBufL2) begin
                drive(I_NO);
                return;
            end
            if (done) fin = 1'b1;
        end
        drive(I_NO);
        start = hold_st;
        if (!fin) begin
            nvec++;
            nerr++;
            $display("FAIL run_timeout: done never seen, required within 2000 cycles");
            return;
        end
        chk("run_cycles", cyc, 3 + n1 * w1 + n2 * 9);
        chk("l1_store_pulses", s1, n1);
        chk("l2_store_pulses", s2, n2);
        chk("initLdL2_pulses", il2, 1);
        chk("initLdL2_after_l1", il2_at, n1);
        chk("l1_cnt_at_done", l1_cnt, n1);
        chk("l2_cnt_at_done", l2_cnt, n2);
        @(posedge clk); #1;
        if (hold_st) begin
            chk("b2b_init", outs, O_L1I);
            chk("b2b_l1_cnt_clear", l1_cnt, 0);
        end else begin
            chk("after_done_idle", outs, O_IDLE);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach summary");
        $fatal(1);
    end

    initial begin
        int n;
        setv(0,  I_NO,          O_IDLE, 0, 0);
        setv(1,  I_ST,          O_L1I,  0, 0);
        setv(2,  I_LD1,         O_L1L,  0, 0);
        setv(3,  I_LD1,         O_L1S,  0, 0);
        setv(4,  I_PE1,         O_WAIT, 0, 0);
        setv(5,  I_PE1,         O_WAIT, 0, 0);
        setv(6,  I_PE1 | I_CT1, O_L1T,  0, 0);
        setv(7,  I_NO,          O_L1L,  1, 0);
        setv(8,  I_LD1 | I_PE1, O_L1S,  1, 0);
        setv(9,  I_NO,          O_WAIT, 1, 0);
        setv(10, I_NO,          O_WAIT, 1, 0);
        setv(11, I_PE1,         O_L1T,  1, 0);
        setv(12, I_CT1,         O_L2I,  2, 0);
        setv(13, I_ST,          O_L2L,  2, 0);
        setv(14, I_LD1,         O_L2L,  2, 0);
        setv(15, I_LD2,         O_L2S,  2, 0);
        setv(16, I_PE2,         O_WAIT, 2, 0);
        setv(17, I_PE2,         O_WAIT, 2, 0);
        setv(18, I_PE2,         O_L2T,  2, 0);
        setv(19, I_CT2,         O_DONE, 2, 1);
        setv(20, I_NO,          O_IDLE, 2, 1);
        setv(21, I_NO,          O_IDLE, 2, 1);

        rst = 1'b1;
        drive(I_NO);
        #3;
        chk("reset_outs", outs, O_IDLE);
        chk("reset_l1_cnt", l1_cnt, 0);
        chk("reset_l2_cnt", l2_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_outs", i), outs, tbl[i].out);
            chk($sformatf("vec%0d_l1", i), l1_cnt, tbl[i].l1);
            chk($sformatf("vec%0d_l2", i), l2_cnt, tbl[i].l2);
        end
        drive(I_NO);

        run(4, 2, 1'b0, 1'b0, 1'b0, 1'b0);   // nominal
        run(4, 2, 1'b1, 1'b0, 1'b0, 1'b0);   // start pulsed during L1_WAIT
        run(2, 1, 1'b0, 1'b1, 1'b0, 1'b0);   // peDoneL1 stuck high
        run(2, 1, 1'b0, 1'b0, 1'b1, 1'b0);   // start held through DONE
        do_reset();

        // async reset while in L2_LOAD
        run(3, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_ldBufL2", ldBufL2, 1);
        chk("pre_reset_l1_cnt", l1_cnt, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", outs, O_IDLE);
        chk("async_rst_l1_cnt", l1_cnt, 0);
        chk("async_rst_l2_cnt", l2_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", outs, O_IDLE);
        end

        // watchdog: ldBufDoneL1 never arrives
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("wd_init", outs, O_L1I);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (outs != O_L1L) break;
            n++;
        end
        chk("wd_load_cycles", n, 16);
        chk("wd_err_outs", outs, O_ERR);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("wd_err_sticky", outs, O_ERR);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("wd_restart_init", outs, O_L1I);
        @(posedge clk); #1;
        chk("wd_restart_load", outs, O_L1L);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
